// File: rtl/bus_cycle_sequencer.sv
// bus_cycle_sequencer: machine-cycle timing generator for the MCU51 core.
// Produces phase / S-state / remaining-cycle count and the registered external
// bus strobes (ale, psen_n, rd_n, wr_n) for NSTATE S-states per machine cycle.
// MOVX instructions replace the second fetch half of machine cycle 1 with a
// data strobe and idle the first half of machine cycle 2.
// Optional macro SEQ_WAIT_EN: when defined, a low ready at the last data-strobe
// clock freezes the sequence (bounded by WAIT_MAX clocks, wait_timeout pulse).
// When undefined, ready is ignored and wait_timeout is tied low.
module bus_cycle_sequencer #(
   parameter int NSTATE   = 6,
   parameter int CYC_W    = 2,
   parameter int WAIT_MAX = 7
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CYC_W-1:0]          cycles_in,
   input  logic                      movx,
   input  logic                      movx_wr,
   input  logic                      ready,
   output logic                      phase,
   output logic [$clog2(NSTATE)-1:0] s_state,
   output logic [CYC_W-1:0]          cycles,
   output logic                      ale,
   output logic                      psen_n,
   output logic                      rd_n,
   output logic                      wr_n,
   output logic                      op_load,
   output logic                      wait_timeout
);

   localparam int SW = $clog2(NSTATE);
   localparam int H  = NSTATE / 2;

   localparam logic [SW-1:0] S_LAST = SW'(NSTATE - 1);
   localparam logic [SW-1:0] S_HALF = SW'(H);
   localparam logic [SW-1:0] S_ONE  = SW'(1);
   localparam logic [SW-1:0] S_TWO  = SW'(2);

   // Kind of the current machine cycle as far as the bus is concerned.
   // MC_DATA is only entered after the MOVX decode is sampled at S1 P2, so the
   // first fetch half of a MOVX machine cycle 1 is always a normal fetch.
   typedef enum logic [1:0] {
      MC_FETCH  = 2'd0,
      MC_DATA   = 2'd1,
      MC_IDLE_A = 2'd2
   } mc_t;

   mc_t                mode, mode_nx;
   logic               first_mc, first_nx;
   logic               dir_wr, dir_wr_nx;
   logic               phase_nx;
   logic [SW-1:0]      s_nx;
   logic [CYC_W-1:0]   cyc_nx;
   logic               freeze;

   // Strobe decode of the next state (registered so the pins never glitch).
   logic               half_b;
   logic [SW-1:0]      hpos;
   logic               win;
   logic               ale_nx, psen_nx, rd_nx, wr_nx, op_nx;

`ifdef SEQ_WAIT_EN
   localparam int WCW = $clog2(WAIT_MAX + 1);
   localparam logic [WCW-1:0] W_LIM = WCW'(WAIT_MAX);

   logic [WCW-1:0]     wcnt, wcnt_nx;
   logic               tmo_nx;
   logic               strobe_end;
`else
   // ready has no function without wait-state support.
   logic               unused_ready;
   assign unused_ready = ready;
`endif

   // Next-state computation: wait handling, S-state sequencing, decode sampling
   // and the strobe pattern of the state being entered.
   always_comb begin
      phase_nx  = phase;
      s_nx      = s_state;
      cyc_nx    = cycles;
      mode_nx   = mode;
      first_nx  = first_mc;
      dir_wr_nx = dir_wr;
      freeze    = 1'b0;
`ifdef SEQ_WAIT_EN
      wcnt_nx    = wcnt;
      tmo_nx     = 1'b0;
      strobe_end = (mode == MC_DATA) && (s_state == S_LAST) && phase;
      // The last data-strobe clock stretches while the device is not ready.
      // A ready arriving together with the limit counts as a normal release.
      if (strobe_end) begin
         if (ready) begin
            wcnt_nx = '0;
         end else if (wcnt == W_LIM) begin
            wcnt_nx = '0;
            tmo_nx  = 1'b1;
         end else begin
            wcnt_nx = wcnt + WCW'(1);
            freeze  = 1'b1;
         end
      end
`endif

      if (!freeze) begin
         phase_nx = ~phase;
         if (phase) begin
            if (s_state == S_LAST) begin
               s_nx     = '0;
               first_nx = (cycles == '0);
               if (cycles != '0) begin
                  cyc_nx = cycles - CYC_W'(1);
               end
               mode_nx = (mode == MC_DATA) ? MC_IDLE_A : MC_FETCH;
            end else begin
               s_nx = s_state + S_ONE;
            end
            // Decode of a new instruction is taken only at S1 P2 of its first
            // machine cycle; later S1 states ignore it.
            if ((s_state == '0) && first_mc) begin
               cyc_nx    = cycles_in;
               mode_nx   = movx ? MC_DATA : MC_FETCH;
               dir_wr_nx = movx_wr;
               first_nx  = 1'b0;
            end
         end
      end

      // Position inside the bus half-cycle the next state belongs to.
      if (s_nx >= S_HALF) begin
         half_b = 1'b1;
         hpos   = s_nx - S_HALF;
      end else begin
         half_b = 1'b0;
         hpos   = s_nx;
      end
      // Strobe window: P2 of the half's second state through P2 of its last.
      win = ((hpos == S_ONE) && phase_nx) || (hpos >= S_TWO);

      ale_nx  = (hpos == '0);
      psen_nx = ~win;
      rd_nx   = 1'b1;
      wr_nx   = 1'b1;
      if (!half_b && (mode_nx == MC_IDLE_A)) begin
         ale_nx  = 1'b0;
         psen_nx = 1'b1;
      end
      if (half_b && (mode_nx == MC_DATA)) begin
         psen_nx = 1'b1;
         if (dir_wr_nx) begin
            wr_nx = ~win;
         end else begin
            rd_nx = ~win;
         end
      end
      op_nx = (s_nx == S_LAST) && phase_nx && (cyc_nx == '0) && !freeze;
   end

   // Sequencer state and registered bus strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         phase    <= 1'b0;
         s_state  <= S_LAST;
         cycles   <= '0;
         mode     <= MC_FETCH;
         first_mc <= 1'b1;
         dir_wr   <= 1'b0;
         ale      <= 1'b0;
         psen_n   <= 1'b1;
         rd_n     <= 1'b1;
         wr_n     <= 1'b1;
         op_load  <= 1'b0;
      end else begin
         phase    <= phase_nx;
         s_state  <= s_nx;
         cycles   <= cyc_nx;
         mode     <= mode_nx;
         first_mc <= first_nx;
         dir_wr   <= dir_wr_nx;
         ale      <= ale_nx;
         psen_n   <= psen_nx;
         rd_n     <= rd_nx;
         wr_n     <= wr_nx;
         op_load  <= op_nx;
      end
   end

`ifdef SEQ_WAIT_EN
   // Wait counter and one-clock timeout pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         wcnt         <= '0;
         wait_timeout <= 1'b0;
      end else begin
         wcnt         <= wcnt_nx;
         wait_timeout <= tmo_nx;
      end
   end
`else
   assign wait_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Scoreboard bench for bus_cycle_sequencer: the driver issues instructions
// (random and directed), a reference model expands each into the expected
// per-clock output stream, and a monitor compares the DUT against it.
`timescale 1ns/1ps
module tb_bus_cycle_sequencer;

   localparam int NSTATE   = 6;
   localparam int CYC_W    = 2;
   localparam int WAIT_MAX = 7;
   localparam int SW       = $clog2(NSTATE);
   localparam int H        = NSTATE / 2;

   logic               clk = 1'b0;
   logic               reset;
   logic [CYC_W-1:0]   cycles_in;
   logic               movx, movx_wr, ready;
   logic               phase;
   logic [SW-1:0]      s_state;
   logic [CYC_W-1:0]   cycles;
   logic               ale, psen_n, rd_n, wr_n, op_load, wait_timeout;

   always #5 clk = ~clk;

   bus_cycle_sequencer #(.NSTATE(NSTATE), .CYC_W(CYC_W), .WAIT_MAX(WAIT_MAX)) dut (
      .clk(clk), .reset(reset), .cycles_in(cycles_in), .movx(movx),
      .movx_wr(movx_wr), .ready(ready), .phase(phase), .s_state(s_state),
      .cycles(cycles), .ale(ale), .psen_n(psen_n), .rd_n(rd_n), .wr_n(wr_n),
      .op_load(op_load), .wait_timeout(wait_timeout)
   );

   typedef struct packed {
      logic            ph;
      logic [SW-1:0]   s;
      logic [CYC_W-1:0] cy;
      logic            ale;
      logic            psen_n;
      logic            rd_n;
      logic            wr_n;
      logic            op;
      logic            to;
   } exp_t;

   exp_t exp_q[$];
   exp_t gen_q[$];
   exp_t rst_e, tail_e, mon_e, mon_a;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   clk_no   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected outputs of one whole instruction, clock by clock, derived from
   // the timing rules: 2 clks per S-state, halves of H states, MOVX data half,
   // idle half, and the stretched last data-strobe clock.
   task automatic build(input int c, input bit m, input bit w, input int n);
      int   f, hp;
      bit   to, pend, hb, win, idle, data;
      exp_t e;
      f = 0; to = 1'b0; pend = 1'b0;
`ifdef SEQ_WAIT_EN
      if (m) begin
         f  = (n < WAIT_MAX) ? n : WAIT_MAX;
         to = (n > WAIT_MAX);
      end
`endif
      gen_q.delete();
      for (int mc = 0; mc <= c; mc++) begin
         for (int s = 0; s < NSTATE; s++) begin
            for (int p = 0; p < 2; p++) begin
               hp   = s % H;
               hb   = (s >= H);
               win  = ((hp == 1) && (p == 1)) || (hp >= 2);
               idle = m && (mc == 1) && !hb;
               data = m && (mc == 0) && hb;
               e.ph     = (p == 1);
               e.s      = SW'(s);
               e.cy     = ((mc == 0) && (s == 0)) ? '0 : CYC_W'(c - mc);
               e.ale    = (hp == 0) && !idle;
               e.psen_n = !(win && !idle && !data);
               e.rd_n   = !(data && win && !w);
               e.wr_n   = !(data && win && w);
               e.op     = (mc == c) && (s == NSTATE - 1) && (p == 1);
               e.to     = pend;
               pend     = 1'b0;
               gen_q.push_back(e);
               if (data && (s == NSTATE - 1) && (p == 1)) begin
                  e.op = 1'b0;
                  for (int k = 0; k < f; k++) gen_q.push_back(e);
                  pend = to;
               end
            end
         end
      end
   endtask

   // Drive one instruction. Decode inputs are valid only in clks 0-1 and are
   // randomised elsewhere; ready is scripted at the strobe end, random otherwise.
   // abort >= 0 asserts reset during that clock of the instruction.
   task automatic run_instr(input int c, input bit m, input bit w, input int n, input int abort);
      int base, f, len;
      build(c, m, w, n);
      len  = gen_q.size();
      base = 2 * NSTATE - 1;
      f    = len - 2 * NSTATE * (c + 1);
      for (int j = 0; j < len; j++) begin
         if (j <= 1) begin
            cycles_in = CYC_W'(c); movx = m; movx_wr = w;
         end else begin
            cycles_in = CYC_W'($urandom); movx = 1'($urandom); movx_wr = 1'($urandom);
         end
         if (m && (j >= base) && (j <= base + f)) ready = ((j - base) >= n);
         else ready = 1'($urandom);
         exp_q.push_back(gen_q[j]);
         if (j == abort) begin
            reset = 1'b1;
            tick();
            exp_q.push_back(rst_e);
            reset = 1'b0;
            tick();
            exp_q.push_back(tail_e);
            tick();
            return;
         end
         tick();
      end
   endtask

   // Monitor: compare every clock that has an expectation queued.
   initial begin
      forever begin
         @(negedge clk);
         clk_no++;
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {phase, s_state, cycles, ale, psen_n, rd_n, wr_n, op_load, wait_timeout};
            n_checks++;
            if (mon_a !== mon_e) begin
               n_fail++;
               $display("FAIL outputs clk %0d: got ph=%0d s=%0d cy=%0d ale=%0d psen_n=%0d rd_n=%0d wr_n=%0d op_load=%0d wto=%0d, required ph=%0d s=%0d cy=%0d ale=%0d psen_n=%0d rd_n=%0d wr_n=%0d op_load=%0d wto=%0d",
                        clk_no, mon_a.ph, mon_a.s, mon_a.cy, mon_a.ale, mon_a.psen_n, mon_a.rd_n, mon_a.wr_n, mon_a.op, mon_a.to,
                        mon_e.ph, mon_e.s, mon_e.cy, mon_e.ale, mon_e.psen_n, mon_e.rd_n, mon_e.wr_n, mon_e.op, mon_e.to);
            end
         end
      end
   end

   // Driver.
   initial begin
      int c, n;
      bit m, w;
      reset = 1'b1; cycles_in = '0; movx = 1'b0; movx_wr = 1'b0; ready = 1'b1;
      rst_e  = {1'b0, SW'(NSTATE - 1), {CYC_W{1'b0}}, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tail_e = {1'b1, SW'(NSTATE - 1), {CYC_W{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

      tick();
      exp_q.push_back(rst_e);
      tick();
      exp_q.push_back(rst_e);
      reset = 1'b0;
      tick();
      exp_q.push_back(tail_e);
      tick();

      // Plain fetches, multi-cycle, MOVX read/write, waits, limits, reset.
      for (int i = 0; i < 3; i++) run_instr(0, 1'b0, 1'b0, 0, -1);
      run_instr(1, 1'b0, 1'b0, 0, -1);
      run_instr(1, 1'b0, 1'b0, 0, -1);
      run_instr(1, 1'b1, 1'b0, 0, -1);
      run_instr(1, 1'b1, 1'b1, 3, -1);
      run_instr(1, 1'b1, 1'b1, WAIT_MAX + 3, -1);
      run_instr(0, 1'b0, 1'b0, 0, -1);
      run_instr(1, 1'b1, 1'b0, WAIT_MAX, -1);
      run_instr(1, 1'b1, 1'b0, WAIT_MAX - 1, -1);
      run_instr((1 << CYC_W) - 1, 1'b0, 1'b0, 0, -1);
      run_instr(1, 1'b1, 1'b0, 0, 2 * NSTATE - 2);
      run_instr(0, 1'b0, 1'b0, 0, -1);

      for (int i = 0; i < 40; i++) begin
         m = ($urandom_range(0, 3) == 0);
         w = 1'($urandom);
         c = m ? 1 : int'($urandom_range(0, (1 << CYC_W) - 1));
         n = m ? int'($urandom_range(0, WAIT_MAX + 3)) : 0;
         run_instr(c, m, w, n, -1);
      end

      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard drain: got %0d entries left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_cycle_sequencer.md
Name: bus_cycle_sequencer

Overview:
Parametrised machine-cycle timing generator for the MCU51 core. It generates the phase, the S-state and the remaining-cycles count, plus the external bus strobes (ALE, PSEN_n, RD_n, WR_n). It generalises the fixed six-state timing to NSTATE states per machine cycle and adds ready-driven wait states on MOVX data accesses. It sits between the instruction decode logic (which supplies the cycle count and the MOVX type) and the external memory bus pins.

Parameters:
NSTATE, 6, S-states per machine cycle; even, >= 4. H = NSTATE/2 is the length of one bus half-cycle.
CYC_W, 2, width of the remaining-machine-cycle counter.
WAIT_MAX, 7, maximum wait clocks before forced continuation; >= 1.

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high
cycles_in  in  CYC_W  extra machine cycles of the new instruction (combinational decode of IR)
movx  in  1  new instruction is MOVX
movx_wr  in  1  MOVX direction: 1 = write, 0 = read
ready  in  1  external data-memory ready
phase  out  1  0 = P1, 1 = P2
s_state  out  $clog2(NSTATE)  current S-state index; 0 = S1
cycles  out  CYC_W  machine cycles remaining after the current one
ale  out  1  address latch enable, active high
psen_n  out  1  program store enable, active low
rd_n  out  1  external data read strobe, active low
wr_n  out  1  external data write strobe, active low
op_load  out  1  one-clk pulse: opcode load point
wait_timeout  out  1  one-clk pulse: wait limit reached

Behaviour:
- Reset values: phase=0, s_state=NSTATE-1, cycles=0, ale=0, psen_n=1, rd_n=1, wr_n=1, op_load=0, wait_timeout=0, internal movx flags cleared, wait counter=0. Reset has priority over every other event, including a wait freeze or a data strobe in progress.
- Timing: each S-state is 2 clk (P1, then P2). phase toggles every clk unless frozen. s_state advances at the end of P2 and wraps NSTATE-1 -> 0.
- op_load: asserted during the final state's P2 when cycles==0. The first pulse comes 1 clk after reset is released.
- Cycle count:
  - In the first machine cycle of an instruction, cycles_in, movx and movx_wr are sampled at the end of S1 P2; cycles reads 0 during S1.
  - At the end of the final state P2, cycles decrements if non-zero.
  - cycles_in is ignored outside the first S1.
- Fetch half (A = states 0..H-1; B = states H..NSTATE-1, each in normal operation):
  - ale high for both phases of the half's first state.
  - psen_n low from P2 of the half's second state through P2 of its last state.
  - All strobes are registered; no combinational glitches.
- MOVX, machine cycle 1, half B: ale asserted as normal; psen_n held high; rd_n (movx_wr=0) or wr_n (movx_wr=1) low over the same window psen_n would use.
- MOVX, machine cycle 2, half A: ale and psen_n suppressed (bus idle). Half B is a normal fetch.
- Wait states: at the last data-strobe clk (state NSTATE-1 P2, MOVX MC1):
  - If ready==0, phase and s_state freeze and the active strobe stays low.
  - Each frozen clk increments the wait counter.
  - Release on ready==1, or when the counter reaches WAIT_MAX. At the limit, wait_timeout pulses for 1 clk and the sequence proceeds regardless.
  - The counter clears on release.
  - ready is ignored at every other time.
- Boundaries:
  - cycles_in at its maximum value (2^CYC_W - 1) is legal.
  - If ready rises on the same clk the limit is hit, treat it as a ready release: no timeout pulse.

Optional Feature:
SEQ_WAIT_EN — when defined, wait-state logic is present as described above. When undefined, ready is ignored, no freeze ever occurs, wait_timeout is tied 0, and the wait counter is not synthesised.

Test Plan:
- Release reset, cycles_in=0, movx=0, NSTATE=6 -> op_load every 12 clk; ale high clks 1-2 and 7-8 of each machine cycle; psen_n low clks 4-6 and 10-12.
- cycles_in=1, movx=0 -> op_load period 24 clk; cycles reads 1 from S2 of MC1 through the end of MC1, then 0 in MC2.
- movx=1, movx_wr=0, cycles_in=1, ready=1 -> MC1: S4 ale=1, psen_n=1 in S5-S6, rd_n=0 from S5P2 to S6P2. MC2: ale=0 in S1, psen_n=1 in S2-S3, normal fetch in S4-S6.
- MOVX write, ready=0 for 3 clk at S6P2 (SEQ_WAIT_EN) -> phase and s_state frozen 3 clk, wr_n low 3 extra clk, op_load period 27, wait_timeout=0.
- ready held 0 with WAIT_MAX=7 -> freeze 7 clk, wait_timeout=1 for exactly 1 clk, sequence resumes, next op_load follows normally.
- reset asserted while rd_n=0 -> next clk: rd_n=1, ale=0, s_state=5, phase=0, cycles=0; op_load 1 clk after release.
